seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_pkg.sv | 20 ++
 rtl/seg_hex_decode.sv | 14 +
 rtl/seg_scan_ctrl.sv | 150 +++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and the hex-to-seven-segment table for the digit scan controller.
// Segment order is abcdefg with bit 6 = a; table entries are active-high.
package seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_OFF = 7'b000_0000;

  localparam seg_t HEX_TABLE [16] = '{
    7'b111_1110, 7'b011_0000, 7'b110_1101, 7'b111_1001,
    7'b011_0011, 7'b101_1011, 7'b101_1111, 7'b111_0000,
    7'b111_1111, 7'b111_1011, 7'b111_0111, 7'b001_1111,
    7'b100_1110, 7'b011_1101, 7'b100_1111, 7'b100_0111
  };

  function automatic seg_t hex_to_seg(input logic [3:0] nibble);
    return HEX_TABLE[nibble];
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble to active-high segment pattern decoder.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  // Table lookup; every nibble value has an entry
  always_comb begin
    seg = hex_to_seg(nibble);
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with frame-synchronous shadow update,
// per-digit masking and leading-zero blanking.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 100000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   digit_val,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic [NUM_DIGITS-1:0]     blank_mask,
  input  logic                      lz_blank,
  output logic [6:0]                seg_out,
  output logic                      dp_out,
  output logic [NUM_DIGITS-1:0]     an_out,
  output logic                      load_ack,
  output logic                      frame_tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam seg_t SEG_POL = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic DP_POL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [NUM_DIGITS-1:0] AN_POL =
    (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [DIV_W-1:0]          div_r;
  logic [IDX_W-1:0]          idx_r;
  logic                      started_r;
  logic                      pending_r;
  logic [4*NUM_DIGITS-1:0]   capture_r;
  logic [NUM_DIGITS-1:0]     capture_dp_r;
  logic [4*NUM_DIGITS-1:0]   shadow_r;
  logic [NUM_DIGITS-1:0]     shadow_dp_r;
  seg_t                      seg_r;
  logic                      dp_r;
  logic [NUM_DIGITS-1:0]     an_r;
  logic                      load_ack_r;
  logic                      frame_tick_r;

  logic                      tick_s;
  logic                      boundary_s;
  logic                      commit_s;
  logic [IDX_W-1:0]          idx_next_s;
  logic [4*NUM_DIGITS-1:0]   shadow_next_s;
  logic [NUM_DIGITS-1:0]     shadow_dp_next_s;
  logic [3:0]                nibble_s;
  seg_t                      dec_seg_s;
  logic [NUM_DIGITS-1:0]     lz_dark_s;
  logic                      zero_above_s;
  logic                      dark_s;

  assign tick_s     = (div_r == DIV_LAST);
  // The very first tick after reset only selects digit 0; it does not close a frame
  assign boundary_s = tick_s && started_r && (idx_r == IDX_LAST);
  assign commit_s   = boundary_s && pending_r;

  // Next scan index, and the shadow contents that will be valid after this edge
  always_comb begin
    if (!started_r || (idx_r == IDX_LAST)) begin
      idx_next_s = {IDX_W{1'b0}};
    end else begin
      idx_next_s = idx_r + IDX_W'(1);
    end
    shadow_next_s    = commit_s ? capture_r : shadow_r;
    shadow_dp_next_s = commit_s ? capture_dp_r : shadow_dp_r;
    nibble_s         = shadow_next_s[{idx_next_s, 2'b00} +: 4];
  end

  // Digit i is a leading zero when it and every more significant nibble are zero
  always_comb begin
    zero_above_s = 1'b1;
    lz_dark_s    = {NUM_DIGITS{1'b0}};
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above_s = zero_above_s && (shadow_next_s[4*i +: 4] == 4'h0);
      lz_dark_s[i] = zero_above_s && (i != 0);
    end
    dark_s = blank_mask[idx_next_s] || (lz_blank && lz_dark_s[idx_next_s]);
  end

  seg_hex_decode u_hex_decode (
    .nibble (nibble_s),
    .seg    (dec_seg_s)
  );

  // Divider, scan index, frame pulses and pin-level output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_r        <= {DIV_W{1'b0}};
      idx_r        <= {IDX_W{1'b0}};
      started_r    <= 1'b0;
      load_ack_r   <= 1'b0;
      frame_tick_r <= 1'b0;
      seg_r        <= SEG_OFF ^ SEG_POL;
      dp_r         <= DP_POL;
      an_r         <= AN_POL;
    end else begin
      div_r        <= tick_s ? {DIV_W{1'b0}} : (div_r + DIV_W'(1));
      load_ack_r   <= commit_s;
      frame_tick_r <= boundary_s;
      if (tick_s) begin
        started_r <= 1'b1;
        idx_r     <= idx_next_s;
        if (dark_s) begin
          seg_r <= SEG_OFF ^ SEG_POL;
          dp_r  <= DP_POL;
          an_r  <= AN_POL;
        end else begin
          seg_r <= dec_seg_s ^ SEG_POL;
          dp_r  <= shadow_dp_next_s[idx_next_s] ^ DP_POL;
          an_r  <= (NUM_DIGITS'(1'b1) << idx_next_s) ^ AN_POL;
        end
      end
    end
  end

  // Capture/pending handshake; a load coinciding with a commit stays pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r    <= 1'b0;
      capture_r    <= {(4*NUM_DIGITS){1'b0}};
      capture_dp_r <= {NUM_DIGITS{1'b0}};
      shadow_r     <= {(4*NUM_DIGITS){1'b0}};
      shadow_dp_r  <= {NUM_DIGITS{1'b0}};
    end else begin
      shadow_r    <= shadow_next_s;
      shadow_dp_r <= shadow_dp_next_s;
      if (load) begin
        capture_r    <= digit_val;
        capture_dp_r <= dp_in;
        pending_r    <= 1'b1;
      end else if (commit_s) begin
        pending_r <= 1'b0;
      end
    end
  end

  assign seg_out    = seg_r;
  assign dp_out     = dp_r;
  assign an_out     = an_r;
  assign load_ack   = load_ack_r;
  assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed scoreboard bench for seg_scan_ctrl (4 digits, divide-by-4), one
// active-high instance for the main scenarios and one active-low instance.
module tb_seg_scan_ctrl;

  localparam logic [6:0] S0 = 7'b111_1110;
  localparam logic [6:0] S1 = 7'b011_0000;
  localparam logic [6:0] S2 = 7'b110_1101;
  localparam logic [6:0] S4 = 7'b011_0011;
  localparam logic [6:0] S5 = 7'b101_1011;
  localparam logic [6:0] S7 = 7'b111_0000;
  localparam logic [6:0] S9 = 7'b111_1011;
  localparam logic [6:0] SA = 7'b111_0111;
  localparam logic [6:0] SF = 7'b100_0111;
  localparam logic [6:0] SX = 7'b000_0000;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] digit_val;
  logic [3:0]  dp_in;
  logic [3:0]  blank_mask;
  logic        lz_blank;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  an_out;
  logic        load_ack;
  logic        frame_tick;

  logic        load_al;
  logic [15:0] val_al;
  logic [3:0]  dp_al;
  logic [3:0]  blank_al;
  logic        lz_al;
  logic [6:0]  seg_al;
  logic        dpo_al;
  logic [3:0]  an_al;
  logic        ack_al;
  logic        ft_al;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  seg_scan_ctrl #(.NUM_DIGITS(4), .CLK_DIV(4), .ACTIVE_LOW(0)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .digit_val(digit_val), .dp_in(dp_in),
    .blank_mask(blank_mask), .lz_blank(lz_blank), .seg_out(seg_out), .dp_out(dp_out),
    .an_out(an_out), .load_ack(load_ack), .frame_tick(frame_tick)
  );

  seg_scan_ctrl #(.NUM_DIGITS(4), .CLK_DIV(4), .ACTIVE_LOW(1)) dut_al (
    .clk(clk), .rst_n(rst_n), .load(load_al), .digit_val(val_al), .dp_in(dp_al),
    .blank_mask(blank_al), .lz_blank(lz_al), .seg_out(seg_al), .dp_out(dpo_al),
    .an_out(an_al), .load_ack(ack_al), .frame_tick(ft_al)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic push(input logic [3:0] an, input logic [6:0] seg, input logic dp);
    sb.push_back({an, seg, dp});
  endtask

  task automatic pop_cmp(input string tag, input logic [3:0] an, input logic [6:0] seg,
                         input logic dp);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s: observed output with empty scoreboard", tag);
    end else begin
      e = sb.pop_front();
      chk(tag, {an, seg, dp}, e);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_frame(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) seen = 1'b1;
    end
    chk(tag, {11'd0, seen}, 12'd1);
  endtask

  // Compare four consecutive digit slots of the active-high instance
  task automatic check_frame(input string tag);
    for (int k = 0; k < 4; k++) begin
      pop_cmp(tag, an_out, seg_out, dp_out);
      if (k < 3) step(4);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    load = 1'b0; digit_val = 16'h0000; dp_in = 4'b0000;
    blank_mask = 4'b0000; lz_blank = 1'b0;
    load_al = 1'b0; val_al = 16'h0000; dp_al = 4'b0000;
    blank_al = 4'b0001; lz_al = 1'b0;

    #1 rst_n = 1'b0;
    #1;
    chk("rst_outputs", {an_out, seg_out, dp_out}, {4'b0000, SX, 1'b0});
    chk("rst_pulses", {10'd0, load_ack, frame_tick}, 12'd0);
    chk("rst_outputs_al", {an_al, seg_al, dpo_al}, {4'b1111, 7'b111_1111, 1'b1});
    step(3);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      push(4'b0000, SX, 1'b0);
      pop_cmp("post_rst_dark", an_out, seg_out, dp_out);
      step(1);
    end
    push(4'b0001, S0, 1'b0);
    pop_cmp("first_tick", an_out, seg_out, dp_out);

    // Scan order with 0x12AF
    load = 1'b1; digit_val = 16'h12AF; dp_in = 4'b0010;
    step(1);
    load = 1'b0;
    wait_frame("frame_034");
    chk("ack_034", {11'd0, load_ack}, 12'd1);
    push(4'b0001, SF, 1'b0); push(4'b0010, SA, 1'b1);
    push(4'b0100, S2, 1'b0); push(4'b1000, S1, 1'b0);
    check_frame("scan_034");

    // Leading-zero blanking on, then off
    load = 1'b1; digit_val = 16'h0040; dp_in = 4'b0000; lz_blank = 1'b1;
    step(1);
    load = 1'b0;
    wait_frame("frame_035a");
    push(4'b0001, S0, 1'b0); push(4'b0010, S4, 1'b0);
    push(4'b0000, SX, 1'b0); push(4'b0000, SX, 1'b0);
    check_frame("lz_on");
    lz_blank = 1'b0;
    wait_frame("frame_035b");
    push(4'b0001, S0, 1'b0); push(4'b0010, S4, 1'b0);
    push(4'b0100, S0, 1'b0); push(4'b1000, S0, 1'b0);
    check_frame("lz_off");

    // Mid-frame load while digit 1 is lit
    wait_frame("frame_036a");
    step(4);
    load = 1'b1; digit_val = 16'h5555;
    step(1);
    load = 1'b0;
    step(3);
    push(4'b0100, S0, 1'b0);
    pop_cmp("old_digit2", an_out, seg_out, dp_out);
    chk("no_ack_mid", {11'd0, load_ack}, 12'd0);
    step(4);
    push(4'b1000, S0, 1'b0);
    pop_cmp("old_digit3", an_out, seg_out, dp_out);
    wait_frame("frame_036b");
    chk("ack_036", {11'd0, load_ack}, 12'd1);
    push(4'b0001, S5, 1'b0);
    pop_cmp("new_digit0", an_out, seg_out, dp_out);
    step(1);
    chk("ack_one_cycle", {11'd0, load_ack}, 12'd0);
    load = 1'b1; digit_val = 16'h3333;
    step(1);
    load = 1'b0;
    step(4);
    load = 1'b1; digit_val = 16'h7777;
    step(1);
    load = 1'b0;
    wait_frame("frame_036c");
    chk("ack_double", {11'd0, load_ack}, 12'd1);
    push(4'b0001, S7, 1'b0); push(4'b0010, S7, 1'b0);
    push(4'b0100, S7, 1'b0); push(4'b1000, S7, 1'b0);
    check_frame("second_load_wins");

    // Load on the boundary-edge cycle commits one frame later
    step(3);
    load = 1'b1; digit_val = 16'h9999;
    step(1);
    load = 1'b0;
    chk("ft_037", {11'd0, frame_tick}, 12'd1);
    chk("no_ack_037", {11'd0, load_ack}, 12'd0);
    push(4'b0001, S7, 1'b0);
    pop_cmp("held_037", an_out, seg_out, dp_out);
    wait_frame("frame_037");
    chk("ack_037", {11'd0, load_ack}, 12'd1);
    push(4'b0001, S9, 1'b0); push(4'b0010, S9, 1'b0);
    push(4'b0100, S9, 1'b0); push(4'b1000, S9, 1'b0);
    check_frame("late_commit");

    // Asynchronous reset while digit 2 is lit, with a load pending
    wait_frame("frame_038");
    step(8);
    load = 1'b1; digit_val = 16'h4444;
    step(1);
    load = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_dark", {an_out, seg_out, dp_out}, {4'b0000, SX, 1'b0});
    chk("async_dark_al", {an_al, seg_al, dpo_al}, {4'b1111, 7'b111_1111, 1'b1});
    step(2);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      push(4'b0000, SX, 1'b0);
      pop_cmp("rst038_dark", an_out, seg_out, dp_out);
      step(1);
    end
    push(4'b0001, S0, 1'b0);
    pop_cmp("rst038_digit0", an_out, seg_out, dp_out);
    wait_frame("frame_038b");
    chk("discarded_ack", {11'd0, load_ack}, 12'd0);
    push(4'b0001, S0, 1'b0);
    pop_cmp("discarded_data", an_out, seg_out, dp_out);

    // Active-low pins with digit 0 masked
    load_al = 1'b1; val_al = 16'h0008;
    step(1);
    load_al = 1'b0;
    wait_frame("frame_039");
    chk("ack_al", {10'd0, ack_al, ft_al}, 12'd3);
    push(4'b1111, 7'b111_1111, 1'b1);
    pop_cmp("al_masked0", an_al, seg_al, dpo_al);
    step(4);
    push(4'b1101, 7'b000_0001, 1'b1);
    pop_cmp("al_digit1", an_al, seg_al, dpo_al);

    chk("sb_drained", 12'(sb.size()), 12'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
